// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the M-stage data-memory interface
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DONE} dmem_state_t;

  localparam int          DMEM_TIMEOUT    = 16;
  localparam logic [31:0] DMEM_FAULT_DATA = 32'h0000_0000;

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - word-wide request/acknowledge data bus
interface dmem_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/dmem_timeout_counter.sv
// rtl/dmem_timeout_counter.sv - bounded wait counter for outstanding bus requests
module dmem_timeout_counter
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = DMEM_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT - 1));

  // Saturates at the expiry value so a held enable cannot wrap around.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/dmem_interface.sv
// rtl/dmem_interface.sv - M-stage data-memory bus master with stall, timeout and sticky fault
module dmem_interface
  import dmem_pkg::*;
#(
  parameter int          TIMEOUT    = DMEM_TIMEOUT,
  parameter logic [31:0] FAULT_DATA = DMEM_FAULT_DATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallMemM,
  output logic        mem_fault,
  dmem_if.master      bus
);

  dmem_state_t state, nextState;

  logic        access;
  logic        aligned;
  logic        startReq;
  logic        faultHit;
  logic        expired;
  logic        reqEnd;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [31:0] dataReg;
  logic        faultReg;

  assign access  = MemReadM | MemWriteM;
  assign aligned = (ALUResultM[1:0] == 2'b00);
  // Ack takes priority over timeout when both land in the same cycle.
  assign reqEnd  = (state == REQ) && (bus.bus_ack || expired);

  assign bus.bus_req   = busReq;
  assign bus.bus_we    = busWe;
  assign bus.bus_addr  = busAddr;
  assign bus.bus_wdata = busWdata;
  assign mem_fault     = faultReg;

  dmem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != REQ),
    .enable  (state == REQ),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    StallMemM = 1'b0;
    startReq  = 1'b0;
    faultHit  = 1'b0;
    ReadDataM = dataReg;
    case (state)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            StallMemM = 1'b1;
            startReq  = 1'b1;
            nextState = REQ;
          end else begin
            faultHit  = 1'b1;
            ReadDataM = FAULT_DATA;
          end
        end
      end
      REQ: begin
        StallMemM = 1'b1;
        if (reqEnd) begin
          nextState = DONE;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // A simultaneous read+write request is issued as a write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busReq   <= 1'b0;
      busWe    <= 1'b0;
      busAddr  <= 32'h0;
      busWdata <= 32'h0;
      dataReg  <= 32'h0;
      faultReg <= 1'b0;
    end else begin
      if (startReq) begin
        busReq   <= 1'b1;
        busWe    <= MemWriteM;
        busAddr  <= {ALUResultM[31:2], 2'b00};
        busWdata <= WriteDataM;
      end
      if (reqEnd) begin
        busReq <= 1'b0;
        if (bus.bus_ack) begin
          if (!busWe) begin
            dataReg <= bus.bus_rdata;
          end
        end else begin
          dataReg  <= FAULT_DATA;
          faultReg <= 1'b1;
        end
      end
      if (faultHit) begin
        faultReg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_interface.sv
// tb/tb_dmem_interface.sv - directed self-checking bench for dmem_interface
module tb_dmem_interface;

  localparam int          TO   = 16;
  localparam logic [31:0] FDAT = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMemM;
  logic        mem_fault;

  int checks;
  int errors;

  dmem_if bus ();

  dmem_interface #(
    .TIMEOUT    (TO),
    .FAULT_DATA (FDAT)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallMemM  (StallMemM),
    .mem_fault  (mem_fault),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One M-stage access driven from IDLE through DONE; ackAfter=0 means never ack.
  task automatic runAccess(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int ackAfter,
                           input logic [31:0] expRead, input int expStall,
                           input int expReq);
    int  stalls;
    int  reqs;
    bit  done;
    stalls = 0;
    reqs   = 0;
    done   = 0;
    @(negedge clk);
    MemReadM   = rd;
    MemWriteM  = wr;
    ALUResultM = addr;
    WriteDataM = wdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (StallMemM) stalls++;
      if (bus.bus_req) begin
        reqs++;
        check({tag, " addr"}, bus.bus_addr, addr);
        check({tag, " we"}, {31'b0, bus.bus_we}, {31'b0, wr});
        if (wr) check({tag, " wdata"}, bus.bus_wdata, wdata);
        bus.bus_ack   = (reqs == ackAfter);
        bus.bus_rdata = (reqs == ackAfter) ? rdata : 32'h0BAD_0BAD;
      end else begin
        bus.bus_ack = 1'b0;
      end
      if (!StallMemM && stalls > 0) begin
        done = 1;
        if (rd && !wr) check({tag, " ReadDataM"}, ReadDataM, expRead);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check({tag, " completion"}, 32'd0, 32'd1);
    check({tag, " stall cycles"}, stalls, expStall);
    check({tag, " req cycles"}, reqs, expReq);
  endtask

  task automatic goIdle();
    @(negedge clk);
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    bus.bus_ack = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n     = 1'b0;
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    bus.bus_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    MemReadM      = 1'b0;
    MemWriteM     = 1'b0;
    ALUResultM    = 32'h0;
    WriteDataM    = 32'h0;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = 32'h0;

    #12;
    check("rst bus_req", {31'b0, bus.bus_req}, 32'd0);
    check("rst bus_we", {31'b0, bus.bus_we}, 32'd0);
    check("rst bus_addr", bus.bus_addr, 32'h0);
    check("rst bus_wdata", bus.bus_wdata, 32'h0);
    check("rst ReadDataM", ReadDataM, 32'h0);
    check("rst mem_fault", {31'b0, mem_fault}, 32'd0);
    check("rst StallMemM", {31'b0, StallMemM}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runAccess("load1", 1, 0, 32'h100, 32'h0, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 2, 1);
    runAccess("store1", 0, 1, 32'h204, 32'h1234_5678, 32'h0, 3, 32'h0, 4, 3);
    #1 check("store1 fault", {31'b0, mem_fault}, 32'd0);

    runAccess("b2b a", 1, 0, 32'h300, 32'h0, 32'h1111_1111, 1, 32'h1111_1111, 2, 1);
    runAccess("b2b b", 1, 0, 32'h304, 32'h0, 32'h2222_2222, 1, 32'h2222_2222, 2, 1);
    goIdle();

    @(negedge clk);
    MemReadM   = 1'b1;
    ALUResultM = 32'h103;
    #1;
    check("misal stall", {31'b0, StallMemM}, 32'd0);
    check("misal ReadDataM", ReadDataM, FDAT);
    check("misal fault before", {31'b0, mem_fault}, 32'd0);
    goIdle();
    #1;
    check("misal bus_req", {31'b0, bus.bus_req}, 32'd0);
    check("misal fault set", {31'b0, mem_fault}, 32'd1);
    runAccess("after misal", 1, 0, 32'h108, 32'h0, 32'hA5A5_0001, 1, 32'hA5A5_0001, 2, 1);
    #1 check("fault sticky", {31'b0, mem_fault}, 32'd1);

    doReset();
    #1 check("fault cleared", {31'b0, mem_fault}, 32'd0);
    runAccess("timeout", 1, 0, 32'h200, 32'h0, 32'h0, 0, FDAT, TO + 1, TO);
    #1;
    check("timeout fault", {31'b0, mem_fault}, 32'd1);
    check("timeout bus_req", {31'b0, bus.bus_req}, 32'd0);

    doReset();
    @(negedge clk);
    MemReadM   = 1'b1;
    ALUResultM = 32'h400;
    @(negedge clk);
    #1 check("midreq req1", {31'b0, bus.bus_req}, 32'd1);
    @(negedge clk);
    #1 check("midreq req2", {31'b0, bus.bus_req}, 32'd1);
    rst_n    = 1'b0;
    MemReadM = 1'b0;
    #1;
    check("midreq bus_req", {31'b0, bus.bus_req}, 32'd0);
    check("midreq stall", {31'b0, StallMemM}, 32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.bus_ack   = 1'b1;
    bus.bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus.bus_ack = 1'b0;
    #1;
    check("late ack ReadDataM", ReadDataM, 32'h0);
    check("late ack bus_req", {31'b0, bus.bus_req}, 32'd0);
    check("late ack stall", {31'b0, StallMemM}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
